// File: rtl/postfix_eval.sv
// Postfix expression evaluator: consumes number/operator tokens, evaluates on a
// signed operand stack and reports one result plus error code per expression.
module postfix_eval #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [7:0]       NUMBER_IN,
   input  logic             NUMBER_STB,
   output logic             NUMBER_ACK,
   input  logic [7:0]       SIGN_IN,
   input  logic             SIGN_STB,
   output logic             SIGN_ACK,
   input  logic             END_STB,
   output logic             END_ACK,
   output logic [WIDTH-1:0] RESULT,
   output logic [2:0]       ERR_CODE,
   output logic             RESULT_STB,
   input  logic             RESULT_ACK,
   output logic             BUSY
);

   localparam int AW  = $clog2(DEPTH);
   localparam int SPW = AW + 1;
   localparam int CW  = $clog2(WIDTH + 1);

   localparam logic [2:0] S_ACCEPT = 3'd0;
   localparam logic [2:0] S_EXEC   = 3'd1;
   localparam logic [2:0] S_DIV    = 3'd2;
   localparam logic [2:0] S_RESULT = 3'd3;
   localparam logic [2:0] S_DRAIN  = 3'd4;

   localparam logic [SPW-1:0] SP_FULL  = SPW'(DEPTH);
   localparam logic [CW-1:0]  DIV_LAST = CW'(WIDTH);

   localparam logic [7:0] OP_ADD = 8'd43;
   localparam logic [7:0] OP_SUB = 8'd45;
   localparam logic [7:0] OP_MUL = 8'd42;
   localparam logic [7:0] OP_DIV = 8'd47;

   logic [2:0]       state_reg;
   logic [SPW-1:0]   sp_reg;
   logic [2:0]       err_reg;
   logic [WIDTH-1:0] result_reg;
   logic             result_stb_reg;
   logic             number_ack_reg;
   logic             sign_ack_reg;
   logic             end_ack_reg;
   logic [7:0]       op_reg;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [WIDTH-1:0] rem_reg;
   logic [WIDTH-1:0] quot_reg;
   logic             neg_reg;
   logic [CW-1:0]    cnt_reg;

   logic [WIDTH-1:0] stack_mem [DEPTH];

   logic             any_ack;
   logic             can_accept;
   logic             take_num;
   logic             take_sign;
   logic             take_end;
   logic             sign_valid;
   logic [WIDTH-1:0] top_val;
   logic [WIDTH-1:0] next_val;
   logic [WIDTH-1:0] top_mag;
   logic [WIDTH-1:0] next_mag;
   logic [WIDTH-1:0] exec_val;
   logic [WIDTH:0]   div_shift;
   logic [WIDTH:0]   div_diff;
   logic [WIDTH-1:0] quot_final;
   logic             push_en;
   logic [WIDTH-1:0] push_val;

   assign any_ack    = number_ack_reg | sign_ack_reg | end_ack_reg;
   assign can_accept = ((state_reg == S_ACCEPT) || (state_reg == S_DRAIN)) && !any_ack;
   assign take_num   = can_accept && NUMBER_STB;
   assign take_sign  = can_accept && !NUMBER_STB && SIGN_STB;
   assign take_end   = can_accept && !NUMBER_STB && !SIGN_STB && END_STB;
   assign sign_valid = (SIGN_IN == OP_ADD) || (SIGN_IN == OP_SUB) ||
                       (SIGN_IN == OP_MUL) || (SIGN_IN == OP_DIV);

   assign top_val  = stack_mem[AW'(sp_reg - SPW'(1))];
   assign next_val = stack_mem[AW'(sp_reg - SPW'(2))];
   assign top_mag  = top_val[WIDTH-1]  ? -top_val  : top_val;
   assign next_mag = next_val[WIDTH-1] ? -next_val : next_val;

   always_comb begin
      exec_val = a_reg + b_reg;
      case (op_reg)
         OP_SUB:  exec_val = a_reg - b_reg;
         OP_MUL:  exec_val = a_reg * b_reg;
         default: exec_val = a_reg + b_reg;
      endcase
   end

   // Restoring step: shift the next dividend bit into the remainder, subtract
   // the divisor, and keep the difference only when it did not borrow.
   assign div_shift  = {rem_reg, quot_reg[WIDTH-1]};
   assign div_diff   = div_shift - {1'b0, b_reg};
   assign quot_final = neg_reg ? -quot_reg : quot_reg;

   always_comb begin
      push_en  = 1'b0;
      push_val = {{(WIDTH-8){1'b0}}, NUMBER_IN};
      if (state_reg == S_ACCEPT && take_num && sp_reg != SP_FULL) begin
         push_en = 1'b1;
      end else if (state_reg == S_EXEC) begin
         push_en  = 1'b1;
         push_val = exec_val;
      end else if (state_reg == S_DIV && cnt_reg == DIV_LAST) begin
         push_en  = 1'b1;
         push_val = quot_final;
      end
   end

   always_ff @(posedge CLK) begin
      if (push_en && !RST) begin
         stack_mem[AW'(sp_reg)] <= push_val;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_reg      <= S_ACCEPT;
         sp_reg         <= '0;
         err_reg        <= '0;
         result_reg     <= '0;
         result_stb_reg <= 1'b0;
         number_ack_reg <= 1'b0;
         sign_ack_reg   <= 1'b0;
         end_ack_reg    <= 1'b0;
         op_reg         <= '0;
         a_reg          <= '0;
         b_reg          <= '0;
         rem_reg        <= '0;
         quot_reg       <= '0;
         neg_reg        <= 1'b0;
         cnt_reg        <= '0;
      end else begin
         number_ack_reg <= take_num;
         sign_ack_reg   <= take_sign;
         end_ack_reg    <= take_end;
         case (state_reg)
            S_ACCEPT: begin
               if (take_num) begin
                  if (sp_reg == SP_FULL) begin
                     err_reg   <= 3'd2;
                     state_reg <= S_DRAIN;
                  end else begin
                     sp_reg <= sp_reg + SPW'(1);
                  end
               end else if (take_sign) begin
                  if (!sign_valid) begin
                     err_reg   <= 3'd4;
                     state_reg <= S_DRAIN;
                  end else if (sp_reg < SPW'(2)) begin
                     err_reg   <= 3'd1;
                     state_reg <= S_DRAIN;
                  end else begin
                     op_reg <= SIGN_IN;
                     sp_reg <= sp_reg - SPW'(2);
                     if (SIGN_IN == OP_DIV) begin
                        b_reg     <= top_mag;
                        quot_reg  <= next_mag;
                        rem_reg   <= '0;
                        neg_reg   <= top_val[WIDTH-1] ^ next_val[WIDTH-1];
                        cnt_reg   <= '0;
                        state_reg <= S_DIV;
                     end else begin
                        a_reg     <= next_val;
                        b_reg     <= top_val;
                        state_reg <= S_EXEC;
                     end
                  end
               end else if (take_end) begin
                  result_stb_reg <= 1'b1;
                  state_reg      <= S_RESULT;
                  if (sp_reg != SPW'(1)) begin
                     err_reg    <= 3'd5;
                     result_reg <= '0;
                  end else begin
                     result_reg <= top_val;
                  end
               end
            end
            S_EXEC: begin
               sp_reg    <= sp_reg + SPW'(1);
               state_reg <= S_ACCEPT;
            end
            S_DIV: begin
               if (cnt_reg == '0 && b_reg == '0) begin
                  err_reg   <= 3'd3;
                  state_reg <= S_DRAIN;
               end else if (cnt_reg == DIV_LAST) begin
                  sp_reg    <= sp_reg + SPW'(1);
                  state_reg <= S_ACCEPT;
               end else begin
                  if (div_diff[WIDTH]) begin
                     rem_reg  <= div_shift[WIDTH-1:0];
                     quot_reg <= {quot_reg[WIDTH-2:0], 1'b0};
                  end else begin
                     rem_reg  <= div_diff[WIDTH-1:0];
                     quot_reg <= {quot_reg[WIDTH-2:0], 1'b1};
                  end
                  cnt_reg <= cnt_reg + CW'(1);
               end
            end
            S_DRAIN: begin
               if (take_end) begin
                  result_reg     <= '0;
                  result_stb_reg <= 1'b1;
                  state_reg      <= S_RESULT;
               end
            end
            S_RESULT: begin
               if (RESULT_ACK && result_stb_reg) begin
                  result_stb_reg <= 1'b0;
                  result_reg     <= '0;
                  sp_reg         <= '0;
                  err_reg        <= '0;
                  state_reg      <= S_ACCEPT;
               end
            end
            default: state_reg <= S_ACCEPT;
         endcase
      end
   end

   assign NUMBER_ACK = number_ack_reg;
   assign SIGN_ACK   = sign_ack_reg;
   assign END_ACK    = end_ack_reg;
   assign RESULT     = result_reg;
   assign ERR_CODE   = err_reg;
   assign RESULT_STB = result_stb_reg;
   assign BUSY       = (state_reg != S_ACCEPT) || NUMBER_STB || SIGN_STB || END_STB;

endmodule

// File: doc/postfix_eval.md
Name: postfix_eval

Overview:
Downstream stage of the infix-to-postfix converter. Consumes its postfix token stream (8-bit numbers on the number channel, ASCII operators on the sign channel) and evaluates the expression on an internal signed operand stack. Emits one result, with an error code, per expression when the end-of-expression strobe arrives.

Parameters:
WIDTH, 32, operand/result width in bits, two's complement.
DEPTH, 16, operand stack entries (power of 2, >=2).

Ports:
CLK  in  1  clock; all state updates on rising edge.
RST  in  1  synchronous, active-high reset.
NUMBER_IN  in  8  unsigned operand, zero-extended to WIDTH.
NUMBER_STB  in  1  operand valid; held until NUMBER_ACK.
NUMBER_ACK  out  1  one-cycle accept pulse.
SIGN_IN  in  8  ASCII operator: "+" (43), "-" (45), "*" (42), "/" (47).
SIGN_STB  in  1  operator valid; held until SIGN_ACK.
SIGN_ACK  out  1  one-cycle accept pulse.
END_STB  in  1  end of expression; held until END_ACK.
END_ACK  out  1  one-cycle accept pulse.
RESULT  out  WIDTH  signed result (0 when ERR_CODE!=0).
ERR_CODE  out  3  0 ok, 1 underflow, 2 overflow, 3 divide by zero, 4 bad sign, 5 bad end depth.
RESULT_STB  out  1  result valid; held until RESULT_ACK.
RESULT_ACK  in  1  result consumed.
BUSY  out  1  high when state != ACCEPT or any input STB high.

Behaviour:
- Reset: all outputs 0, stack pointer 0, state ACCEPT, sticky error 0. Reset mid-operation (incl. DIV) aborts immediately with the same values; no ACK or RESULT_STB is issued for the aborted item.
- Handshake: an item is accepted on an edge where its STB=1 in ACCEPT/DRAIN and no ACK is currently high. The ACK is registered and high exactly the following cycle. No acceptance on an edge where any ACK is high. Source may drop STB or present the next item on the edge where ACK is high.
- Priority when several STBs are high: NUMBER > SIGN > END; only one accepted per edge.
- States: ACCEPT, EXEC, DIV, RESULT, DRAIN.
- ACCEPT, number: if sp==DEPTH then ERR=2, go DRAIN. Otherwise push the zero-extended value, sp+1, stay ACCEPT.
- ACCEPT, sign: if SIGN_IN is not one of the four operators, ERR=4, go DRAIN. Else if sp<2, ERR=1, go DRAIN. Else latch op, B=top, A=top-1, sp-2, go EXEC ("+","-","*") or DIV ("/").
- ACCEPT, END: if sp!=1, ERR=5 and RESULT=0. Else RESULT=top. Go RESULT.
- EXEC: 1 cycle. Push A op B, truncated to WIDTH (wrap). "*" keeps the low WIDTH bits of the signed product. Return to ACCEPT; operator-to-ready latency is 2 cycles.
- DIV:
  - If B==0: ERR=3, go DRAIN (1 cycle).
  - Otherwise: iterative restoring division on magnitudes, 1 quotient bit per cycle, WIDTH cycles. Then 1 sign-fix cycle, push quotient, return to ACCEPT; WIDTH+1 cycles in DIV.
  - Truncates toward zero; remainder discarded. -2^(WIDTH-1)/-1 wraps to -2^(WIDTH-1).
  - No items are accepted during EXEC/DIV (STBs held, BUSY=1).
- DRAIN: accept and ACK numbers and signs with no stack effect. Error code held sticky. On END: RESULT=0, go RESULT.
- RESULT: RESULT_STB=1, RESULT and ERR_CODE stable while high. On the edge with RESULT_ACK=1: RESULT_STB<=0, sp<=0, ERR<=0, go ACCEPT. RESULT_ACK is ignored when RESULT_STB=0.
- Stack entries are not cleared on pop; only sp is meaningful.

Test Plan:
- Stream 3,4,"+",2,"*",END -> RESULT=14, ERR_CODE=0; each ACK exactly one cycle; RESULT_STB held until RESULT_ACK.
- Stream 2,5,"-",END -> RESULT=0xFFFFFFFD (-3), ERR_CODE=0. Stream 100,3,"/",END -> 33; divide occupies WIDTH+1 cycles with BUSY=1 and no ACKs.
- Stream 5,0,"/",7,"+",END -> ERR_CODE=3, RESULT=0; 7 and "+" still ACKed in DRAIN.
- Stream 4,"+",END -> ERR_CODE=1. Stream of DEPTH+1 numbers -> ERR_CODE=2 on the (DEPTH+1)th. SIGN_IN="%" -> ERR_CODE=4. Stream 1,2,END -> ERR_CODE=5.
- NUMBER_STB and SIGN_STB high on the same edge -> NUMBER_ACK first, SIGN_ACK on a later cycle. RESULT_ACK withheld 10 cycles -> RESULT and ERR_CODE stable throughout.
- RST asserted mid-DIV (cycle 10 of "200,7,/") -> next cycle all outputs 0, state ACCEPT. A following stream 6,7,"*",END -> 42.
